// File: rtl/fused_mac_pe.sv
// Fused-precision systolic MAC processing element.
// An 8-bit activation and an 8-bit weight are split into 1x8b, 2x4b or 4x2b lanes,
// the lane products are summed into one dot product and added either to the
// upstream partial sum or to a local accumulator. Two register stages, one global
// stall, valid travelling with the data.
module fused_mac_pe #(
    parameter int COL_WIDTH = 11,
    parameter int PSUM_W    = 4 * COL_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              valid_in,
    input  logic [1:0]        mode,
    input  logic              s_in,
    input  logic              s_weight,
    input  logic [7:0]        in,
    input  logic [7:0]        weight,
    input  logic [PSUM_W-1:0] psum_in,
    input  logic              acc_mode,
    input  logic              acc_clr,
    output logic              valid_out,
    output logic [PSUM_W-1:0] psum_fwd
);

    // Lane width selector passed to the extension helper.
    localparam logic [1:0] LW2 = 2'd0;
    localparam logic [1:0] LW4 = 2'd1;
    localparam logic [1:0] LW8 = 2'd2;

    // Extend the low lane bits of a field to 9 bits, sign or zero per sgn.
    function automatic logic signed [8:0] f_ext(input logic [7:0] f, input logic sgn,
                                                 input logic [1:0] lw);
        logic [8:0] v;
        case (lw)
            LW2:     v = {{7{sgn & f[1]}}, f[1:0]};
            LW4:     v = {{5{sgn & f[3]}}, f[3:0]};
            default: v = {sgn & f[7], f};
        endcase
        return signed'(v);
    endfunction

    // Exact signed product of one lane; 9x9 bits always fits in 18.
    function automatic logic signed [17:0] f_lane(input logic [7:0] a, input logic [7:0] b,
                                                  input logic sa, input logic sb,
                                                  input logic [1:0] lw);
        logic signed [17:0] ea;
        logic signed [17:0] eb;
        ea = 18'(f_ext(a, sa, lw));
        eb = 18'(f_ext(b, sb, lw));
        return ea * eb;
    endfunction

    logic signed [17:0]       w_prod_sum;
    logic signed [PSUM_W-1:0] w_base;
    logic signed [PSUM_W-1:0] w_result;

    logic                     r_vld_p1;
    logic signed [17:0]       r_prod_p1;
    logic signed [PSUM_W-1:0] r_psum_p1;
    logic                     r_accm_p1;
    logic                     r_accc_p1;

    logic                     r_vld_p2;
    logic signed [PSUM_W-1:0] r_fwd_p2;
    logic signed [PSUM_W-1:0] r_acc;

    // Fused dot product of the lanes selected by mode (11 behaves as 8x8).
    always_comb begin
        w_prod_sum = '0;
        case (mode)
            2'b01: begin
                w_prod_sum = f_lane({4'b0, in[3:0]}, {4'b0, weight[3:0]}, s_in, s_weight, LW4)
                           + f_lane({4'b0, in[7:4]}, {4'b0, weight[7:4]}, s_in, s_weight, LW4);
            end
            2'b10: begin
                w_prod_sum = f_lane({6'b0, in[1:0]}, {6'b0, weight[1:0]}, s_in, s_weight, LW2)
                           + f_lane({6'b0, in[3:2]}, {6'b0, weight[3:2]}, s_in, s_weight, LW2)
                           + f_lane({6'b0, in[5:4]}, {6'b0, weight[5:4]}, s_in, s_weight, LW2)
                           + f_lane({6'b0, in[7:6]}, {6'b0, weight[7:6]}, s_in, s_weight, LW2);
            end
            default: begin
                w_prod_sum = f_lane(in, weight, s_in, s_weight, LW8);
            end
        endcase
    end

    // Stage 1: capture the product and its controls; invalid beats leave data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_prod_p1 <= '0;
            r_psum_p1 <= '0;
            r_accm_p1 <= 1'b0;
            r_accc_p1 <= 1'b0;
        end else if (!stall) begin
            r_vld_p1 <= valid_in;
            if (valid_in) begin
                r_prod_p1 <= w_prod_sum;
                r_psum_p1 <= psum_in;
                r_accm_p1 <= acc_mode;
                r_accc_p1 <= acc_clr;
            end
        end
    end

    // Pick the addend: cleared or running accumulator, or the upstream psum.
    always_comb begin
        w_base = r_psum_p1;
        if (r_accm_p1) begin
            w_base = r_accc_p1 ? '0 : r_acc;
        end
        w_result = PSUM_W'(r_prod_p1) + w_base;
    end

    // Stage 2: forward the wrapped sum; the accumulator only moves on acc_mode beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2 <= 1'b0;
            r_fwd_p2 <= '0;
            r_acc    <= '0;
        end else if (!stall) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_fwd_p2 <= w_result;
                if (r_accm_p1) begin
                    r_acc <= w_result;
                end
            end
        end
    end

    assign valid_out = r_vld_p2;
    assign psum_fwd  = r_fwd_p2;

endmodule

// File: tb/tb_fused_mac_pe.sv
// Scoreboard bench for fused_mac_pe: a sampling process pushes expected results
// computed from lane arithmetic, a negedge monitor pops and compares them.
module tb_fused_mac_pe;

    localparam int COL_WIDTH = 11;
    localparam int PSUM_W    = 4 * COL_WIDTH;
    localparam logic [63:0] MASK = (64'd1 << PSUM_W) - 64'd1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stall = 1'b0;
    logic              valid_in = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic              s_in = 1'b0;
    logic              s_weight = 1'b0;
    logic [7:0]        in_op = 8'h00;
    logic [7:0]        weight = 8'h00;
    logic [PSUM_W-1:0] psum_in = '0;
    logic              acc_mode = 1'b0;
    logic              acc_clr = 1'b0;
    logic              valid_out;
    logic [PSUM_W-1:0] psum_fwd;

    // Directed beats may carry a hand-computed expected value.
    logic              dir_use = 1'b0;
    logic [PSUM_W-1:0] dir_exp = '0;

    typedef struct {
        logic [PSUM_W-1:0] exp;
        int                t;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    ue = 0;
    bit    last_act = 1'b0;
    logic [63:0] acc_m = 64'd0;
    logic [PSUM_W-1:0] last_fwd = '0;
    logic last_vld = 1'b0;

    always #5 clk = ~clk;

    fused_mac_pe #(.COL_WIDTH(COL_WIDTH), .PSUM_W(PSUM_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .valid_in(valid_in), .mode(mode),
        .s_in(s_in), .s_weight(s_weight), .in(in_op), .weight(weight),
        .psum_in(psum_in), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .valid_out(valid_out), .psum_fwd(psum_fwd)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Dot product straight from the lane rules, in plain integer arithmetic.
    function automatic longint ref_prod(input logic [1:0] m, input logic si, input logic sw,
                                        input logic [7:0] a, input logic [7:0] b);
        int     lw;
        longint fa, fb, sum;
        lw  = (m == 2'b01) ? 4 : (m == 2'b10) ? 2 : 8;
        sum = 0;
        for (int k = 0; k < 8 / lw; k++) begin
            fa = (longint'(a) >> (k * lw)) % (longint'(1) << lw);
            fb = (longint'(b) >> (k * lw)) % (longint'(1) << lw);
            if (si && fa >= (longint'(1) << (lw - 1))) fa = fa - (longint'(1) << lw);
            if (sw && fb >= (longint'(1) << (lw - 1))) fb = fb - (longint'(1) << lw);
            sum = sum + fa * fb;
        end
        return sum;
    endfunction

    longint p_m, base_m;
    logic [63:0] res_m;
    item_t it_in, it_out;
    bit exp_v;

    // Sample accepted beats at the clock edge and queue their expected result.
    always @(posedge clk) begin
        last_act = rst_n && !stall;
        if (!rst_n) begin
            acc_m = 64'd0;
        end else if (!stall) begin
            if (valid_in) begin
                p_m    = ref_prod(mode, s_in, s_weight, in_op, weight);
                base_m = acc_mode ? (acc_clr ? 0 : longint'(acc_m)) : longint'({20'd0, psum_in});
                res_m  = 64'(p_m + base_m) & MASK;
                if (acc_mode) acc_m = res_m;
                it_in.exp = dir_use ? dir_exp : res_m[PSUM_W-1:0];
                it_in.t   = ue;
                q.push_back(it_in);
            end
            ue++;
        end
    end

    // Compare outputs away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid_out", {63'd0, valid_out}, 64'd0);
            chk("rst_psum_fwd", {20'd0, psum_fwd}, 64'd0);
            q.delete();
            last_fwd = '0;
            last_vld = 1'b0;
        end else if (last_act) begin
            exp_v = (q.size() > 0) && (q[0].t + 2 == ue);
            chk("valid_out", {63'd0, valid_out}, {63'd0, exp_v});
            if (exp_v) begin
                it_out = q.pop_front();
                chk("psum_fwd", {20'd0, psum_fwd}, {20'd0, it_out.exp});
                last_fwd = it_out.exp;
            end else begin
                chk("psum_hold", {20'd0, psum_fwd}, {20'd0, last_fwd});
            end
            last_vld = exp_v;
        end else begin
            chk("stall_valid_out", {63'd0, valid_out}, {63'd0, last_vld});
            chk("stall_psum_fwd", {20'd0, psum_fwd}, {20'd0, last_fwd});
        end
    end

    task automatic beat(input logic [1:0] m, input logic si, input logic sw,
                        input logic [7:0] a, input logic [7:0] b, input logic [PSUM_W-1:0] p,
                        input logic am, input logic ac, input logic [PSUM_W-1:0] e);
        mode = m; s_in = si; s_weight = sw; in_op = a; weight = b; psum_in = p;
        acc_mode = am; acc_clr = ac; valid_in = 1'b1; dir_use = 1'b1; dir_exp = e;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0; dir_use = 1'b0; stall = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rand_inputs();
        mode     = 2'($urandom_range(0, 3));
        s_in     = 1'($urandom_range(0, 1));
        s_weight = 1'($urandom_range(0, 1));
        in_op    = 8'($urandom);
        weight   = 8'($urandom);
        psum_in  = PSUM_W'({$urandom, $urandom});
        acc_mode = 1'($urandom_range(0, 1));
        acc_clr  = ($urandom_range(0, 3) == 0);
        valid_in = ($urandom_range(0, 3) != 0);
        dir_use  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        beat(2'b00, 1, 1, 8'hFF, 8'h02, PSUM_W'(5),  0, 0, PSUM_W'(3));
        beat(2'b00, 0, 0, 8'hFF, 8'h02, PSUM_W'(5),  0, 0, PSUM_W'(515));
        beat(2'b00, 1, 0, 8'hFF, 8'h02, PSUM_W'(5),  0, 0, PSUM_W'(3));
        beat(2'b01, 0, 0, 8'h23, 8'h45, PSUM_W'(0),  0, 0, PSUM_W'(23));
        beat(2'b01, 1, 1, 8'hF1, 8'h22, PSUM_W'(0),  0, 0, PSUM_W'(0));
        beat(2'b10, 1, 0, 8'hFF, 8'h55, PSUM_W'(10), 0, 0, PSUM_W'(6));
        beat(2'b00, 0, 0, 8'h01, 8'h01, {PSUM_W{1'b1}}, 0, 0, PSUM_W'(0));
        beat(2'b11, 1, 1, 8'hFF, 8'h02, PSUM_W'(5),  0, 0, PSUM_W'(3));
        beat(2'b00, 0, 0, 8'h03, 8'h03, PSUM_W'(77), 1, 1, PSUM_W'(9));
        beat(2'b00, 0, 0, 8'h02, 8'h02, PSUM_W'(77), 1, 0, PSUM_W'(13));
        beat(2'b00, 1, 1, 8'hFF, 8'h01, PSUM_W'(77), 1, 0, PSUM_W'(12));
        beat(2'b00, 0, 0, 8'h02, 8'h02, PSUM_W'(40), 0, 1, PSUM_W'(44));
        beat(2'b00, 0, 0, 8'h01, 8'h01, PSUM_W'(0),  1, 0, PSUM_W'(13));
        idle(3);

        beat(2'b00, 0, 0, 8'h05, 8'h05, PSUM_W'(0), 1, 1, PSUM_W'(25));
        beat(2'b00, 0, 0, 8'h02, 8'h03, PSUM_W'(0), 1, 0, PSUM_W'(31));
        mode = 2'b00; s_in = 0; s_weight = 0; in_op = 8'h01; weight = 8'h01;
        acc_mode = 1'b1; acc_clr = 1'b0; valid_in = 1'b1; dir_use = 1'b1; dir_exp = PSUM_W'(32);
        stall = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        stall = 1'b0;
        @(posedge clk); #1;
        beat(2'b00, 0, 0, 8'h04, 8'h01, PSUM_W'(0), 1, 0, PSUM_W'(36));
        idle(3);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                stall = 1'b1;
            end else begin
                stall = 1'b0;
                rand_inputs();
            end
            @(posedge clk); #1;
        end
        idle(4);

        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            valid_in = 1'b1;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid_out", {63'd0, valid_out}, 64'd0);
        chk("async_rst_psum_fwd", {20'd0, psum_fwd}, 64'd0);
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        idle(4);

        beat(2'b00, 0, 0, 8'h02, 8'h03, PSUM_W'(0), 1, 0, PSUM_W'(6));
        idle(4);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
